// File: rtl/jtopl_eg_pkg.sv
// jtopl_eg_pkg: shared envelope types, attenuation limit, step pattern table and effective-rate helper
package jtopl_eg_pkg;
    typedef enum logic [1:0] {ATTACK = 2'd0, DECAY = 2'd1, SUSTAIN = 2'd2, RELEASE = 2'd3} eg_state_t;
    localparam logic [8:0] ATT_MAX = 9'h1FF;
    // bit i of PAT[lo] is the step pattern entry for counter phase i
    localparam logic [3:0][7:0] PAT = {8'hFE, 8'hEE, 8'hBA, 8'hAA};
    function automatic logic [5:0] eff_rate(input logic [3:0] rate, input logic ksr, input logic [3:0] kc);
        logic [6:0] sum;
        sum = {1'b0, rate, 2'b0} + {3'b0, ksr ? kc : {2'b0, kc[3:2]}};
        return rate == 4'd0 ? 6'd0 : sum > 7'd63 ? 6'd63 : sum[5:0];
    endfunction
endpackage

// File: rtl/jtopl_eg_step.sv
// jtopl_eg_step: per-strobe attenuation increment for an effective rate and envelope counter value
module jtopl_eg_step
    import jtopl_eg_pkg::*;
(
    input  logic [5:0]  eff,
    input  logic [14:0] eg_cnt,
    output logic [4:0]  inc,
    output logic        step_en
);
    logic [3:0]  hi, sh;
    logic [1:0]  lo;
    logic [14:0] shifted, mask;
    logic [2:0]  idx;
    logic        pat_bit, fast;
    always_comb begin
        hi      = eff[5:2];
        lo      = eff[1:0];
        fast    = hi >= 4'd12;
        sh      = 4'd11 - hi;
        shifted = eg_cnt >> sh;
        mask    = (15'd1 << sh) - 15'd1;
        idx     = fast ? eg_cnt[2:0] : shifted[2:0];
        pat_bit = PAT[lo][idx];
        step_en = eff >= 6'd4 && (fast || (eg_cnt & mask) == 15'd0);
        // fast rates: hi 12..15 maps to base 1,2,4,8, doubled on pattern hits
        inc     = !step_en ? 5'd0 : fast ? (5'd1 << hi[1:0]) << pat_bit : {4'b0, pat_bit};
    end
endmodule

// File: rtl/jtopl_eg_adsr.sv
// jtopl_eg_adsr: per-operator ADSR envelope, one attenuation update per sample strobe
module jtopl_eg_adsr
    import jtopl_eg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        zero,
    input  logic [14:0] eg_cnt,
    input  logic        keyon,
    input  logic [3:0]  ar,
    input  logic [3:0]  dr,
    input  logic [3:0]  rr,
    input  logic [3:0]  sl,
    input  logic        eg_type,
    input  logic        ksr,
    input  logic [3:0]  kc,
    output logic [8:0]  eg_att,
    output logic [1:0]  eg_state,
    output logic        eg_step
);
    eg_state_t   st, ph, nxt_st;
    logic        keyon_q, rise, fall, step_en;
    logic [3:0]  rate;
    logic [5:0]  eff;
    logic [4:0]  inc;
    logic [10:0] prod;
    logic [9:0]  sum;
    logic [8:0]  att_dn, att_up, nxt_att, sl_att;

    jtopl_eg_step u_step (.eff(eff), .eg_cnt(eg_cnt), .inc(inc), .step_en(step_en));

    assign eg_state = st;

    always_comb begin
        rise    = keyon & ~keyon_q;
        fall    = ~keyon & keyon_q;
        ph      = rise ? ATTACK : st;
        rate    = ph == ATTACK ? ar : ph == DECAY ? dr : rr;
        eff     = eff_rate(rate, ksr, kc);
        prod    = ({5'b0, eg_att[8:3]} + 11'd1) * {6'b0, inc};
        att_dn  = eff >= 6'd60 || prod > {2'b0, eg_att} ? 9'd0 : eg_att - prod[8:0];
        sum     = {1'b0, eg_att} + {5'b0, inc};
        att_up  = sum[9] ? ATT_MAX : sum[8:0];
        nxt_att = ph == ATTACK ? att_dn : (ph == SUSTAIN && eg_type) ? eg_att : att_up;
        sl_att  = sl == 4'hF ? ATT_MAX : {1'b0, sl, 4'b0};
        // transitions judge the freshly updated attenuation
        nxt_st  = rise ? ATTACK :
                  fall ? RELEASE :
                  (st == ATTACK && nxt_att == 9'd0) ? DECAY :
                  (st == DECAY && nxt_att >= sl_att) ? SUSTAIN : st;
    end

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            eg_att  <= ATT_MAX;
            st      <= RELEASE;
            eg_step <= 1'b0;
            keyon_q <= 1'b0;
        end else if (cen && zero) begin
            eg_att  <= nxt_att;
            st      <= nxt_st;
            eg_step <= nxt_att != eg_att;
            keyon_q <= keyon;
        end
    end
endmodule
